// File: rtl/conv_frame_encoder.sv
// ============================================================================
// Module   : conv_frame_encoder
// Brief    : Rate-1/2 K=3 (7,5) convolutional encoder framed by a slot index,
//            NUM-2 data slots plus 2 zero tail slots per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_frame_encoder #(
  parameter int NUM = 16
) (
  input  logic                       clk_sig,
  input  logic                       reset_sig,
  input  logic [$clog2(NUM-1)-1:0]   counter_sig,
  input  logic                       en_sig,
  input  logic                       data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [1:0]                 enc_out,
  output logic                       enc_valid,
  output logic                       enc_sof,
  output logic                       enc_eof,
  output logic                       underrun_sig,
  output logic                       slot_err_sig
);

  localparam int W = $clog2(NUM-1);
  localparam logic [W-1:0] C_ZERO      = '0;
  localparam logic [W-1:0] C_ONE       = W'(1);
  localparam logic [W-1:0] C_LAST_DATA = W'(NUM-3);
  localparam logic [W-1:0] C_LAST      = W'(NUM-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_s1, r_s2, w_s1_nxt, w_s2_nxt;
  logic [W-1:0]   r_exp, w_exp_nxt, w_exp_inc;
  logic           w_slot_ok, w_ready, w_emit, w_tail, w_bit;
  logic           w_s1_use, w_s2_use, w_und_set, w_serr_set;
  logic [1:0]     w_pair;

  assign w_exp_inc = r_exp + C_ONE;
  assign w_slot_ok = (counter_sig == w_exp_inc);

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_exp_nxt   = r_exp;
    w_s1_use    = r_s1;
    w_s2_use    = r_s2;
    w_ready     = 1'b0;
    w_emit      = 1'b0;
    w_tail      = 1'b0;
    w_bit       = 1'b0;
    w_und_set   = 1'b0;
    w_serr_set  = 1'b0;

    case (r_state)
      IDLE: begin
        // Frame start: encoder state is forced to zero regardless of history.
        if (en_sig && counter_sig == C_ZERO) begin
          w_ready     = 1'b1;
          w_emit      = 1'b1;
          w_s1_use    = 1'b0;
          w_s2_use    = 1'b0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_ready = 1'b1;
        if (w_slot_ok) begin
          w_emit = 1'b1;
          if (counter_sig == C_LAST_DATA) w_state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (w_slot_ok) begin
          w_emit = 1'b1;
          w_tail = 1'b1;
          if (counter_sig == C_LAST) w_state_nxt = en_sig ? DATA : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Counter discontinuity inside a frame abandons it; the bit is dropped.
    if ((r_state == DATA || r_state == TAIL) && !w_slot_ok) begin
      w_state_nxt = IDLE;
      w_s1_nxt    = 1'b0;
      w_s2_nxt    = 1'b0;
      w_serr_set  = 1'b1;
    end

    if (w_emit) begin
      w_bit     = w_tail ? 1'b0 : (data_valid & data_in);
      w_und_set = !w_tail && !data_valid;
      w_s2_nxt  = w_s1_use;
      w_s1_nxt  = w_bit;
      w_exp_nxt = counter_sig;
    end
  end

  assign w_pair     = {w_bit ^ w_s1_use ^ w_s2_use, w_bit ^ w_s2_use};
  assign data_ready = reset_sig & w_ready;

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_exp        <= '0;
      enc_out      <= 2'b00;
      enc_valid    <= 1'b0;
      enc_sof      <= 1'b0;
      enc_eof      <= 1'b0;
      underrun_sig <= 1'b0;
      slot_err_sig <= 1'b0;
    end else begin
      r_s1         <= w_s1_nxt;
      r_s2         <= w_s2_nxt;
      r_exp        <= w_exp_nxt;
      enc_out      <= w_emit ? w_pair : 2'b00;
      enc_valid    <= w_emit;
      enc_sof      <= w_emit && (counter_sig == C_ZERO);
      enc_eof      <= w_emit && (counter_sig == C_LAST);
      underrun_sig <= underrun_sig | w_und_set;
      slot_err_sig <= slot_err_sig | w_serr_set;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_encoder.sv
// ============================================================================
// Module   : tb_conv_frame_encoder
// Brief    : Directed, table-driven bench for conv_frame_encoder (NUM=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_frame_encoder;

  localparam int NUM = 16;

  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic [3:0] counter_sig;
  logic       en_sig, data_in, data_valid;
  logic       data_ready;
  logic [1:0] enc_out;
  logic       enc_valid, enc_sof, enc_eof, underrun_sig, slot_err_sig;

  conv_frame_encoder #(.NUM(NUM)) dut (
    .clk_sig      (clk_sig),
    .reset_sig    (reset_sig),
    .counter_sig  (counter_sig),
    .en_sig       (en_sig),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .enc_out      (enc_out),
    .enc_valid    (enc_valid),
    .enc_sof      (enc_sof),
    .enc_eof      (enc_eof),
    .underrun_sig (underrun_sig),
    .slot_err_sig (slot_err_sig)
  );

  always #5 clk_sig = ~clk_sig;

  typedef struct {
    logic       en;
    logic [3:0] cnt;
    logic       din;
    logic       dv;
    logic       rdy;
    logic       val;
    logic [1:0] out;
    logic       sof;
    logic       eof;
    logic       und;
    logic       serr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic e_und   = 1'b0;
  logic e_serr  = 1'b0;

  // Expected bundle order: {valid, out[1:0], sof, eof, underrun, slot_err}
  function automatic logic [6:0] bundle();
    return {enc_valid, enc_out, enc_sof, enc_eof, underrun_sig, slot_err_sig};
  endfunction

  function automatic void add(input logic en, input int cnt, input logic din,
                              input logic dv, input logic rdy, input logic val,
                              input logic [1:0] out, input logic sof, input logic eof);
    vec_t v;
    v.en = en; v.cnt = 4'(cnt); v.din = din; v.dv = dv;
    v.rdy = rdy; v.val = val; v.out = out; v.sof = sof; v.eof = eof;
    v.und = e_und; v.serr = e_serr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    en_sig = v.en; counter_sig = v.cnt; data_in = v.din; data_valid = v.dv;
    #2;
    check($sformatf("ready[%0d] slot %0d", idx, v.cnt), {6'd0, data_ready}, {6'd0, v.rdy});
    @(posedge clk_sig); #1;
    check($sformatf("out[%0d] slot %0d", idx, v.cnt), bundle(),
          {v.val, v.out, v.sof, v.eof, v.und, v.serr});
  endtask

  task automatic run_table();
    foreach (vecs[i]) apply(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    reset_sig = 1'b0; en_sig = 1'b1; counter_sig = 4'd0;
    data_in = 1'b1; data_valid = 1'b1;
    repeat (2) @(posedge clk_sig);
    #1;
    check("reset ready", {6'd0, data_ready}, 7'd0);
    check("reset outputs", bundle(), 7'd0);
    en_sig = 1'b0; counter_sig = 4'd14;
    reset_sig = 1'b1;

    // Idle before the first slot 0
    add(1, 14, 1, 1, 0, 0, 2'b00, 0, 0);
    add(1, 15, 1, 1, 0, 0, 2'b00, 0, 0);
    // Frame 1: data 1,0,1,1,0...,1,1 (slots 12,13), then tail flush
    add(1, 0, 1, 1, 1, 1, 2'b11, 1, 0);
    add(1, 1, 0, 1, 1, 1, 2'b10, 0, 0);
    add(1, 2, 1, 1, 1, 1, 2'b00, 0, 0);
    add(1, 3, 1, 1, 1, 1, 2'b01, 0, 0);
    add(1, 4, 0, 1, 1, 1, 2'b01, 0, 0);
    add(1, 5, 0, 1, 1, 1, 2'b11, 0, 0);
    for (int s = 6; s <= 11; s++) add(1, s, 0, 1, 1, 1, 2'b00, 0, 0);
    add(1, 12, 1, 1, 1, 1, 2'b11, 0, 0);
    add(1, 13, 1, 1, 1, 1, 2'b01, 0, 0);
    add(1, 14, 1, 1, 0, 1, 2'b01, 0, 0);
    add(1, 15, 1, 1, 0, 1, 2'b11, 0, 1);
    // Frame 2 back-to-back; en dropped at slot 3; underrun at slot 4
    add(1, 0, 0, 1, 1, 1, 2'b00, 1, 0);
    add(1, 1, 1, 1, 1, 1, 2'b11, 0, 0);
    add(1, 2, 0, 1, 1, 1, 2'b10, 0, 0);
    add(0, 3, 0, 1, 1, 1, 2'b11, 0, 0);
    e_und = 1'b1;
    add(0, 4, 1, 0, 1, 1, 2'b00, 0, 0);
    for (int s = 5; s <= 13; s++) add(0, s, 0, 1, 1, 1, 2'b00, 0, 0);
    add(0, 14, 0, 1, 0, 1, 2'b00, 0, 0);
    add(0, 15, 0, 1, 0, 1, 2'b00, 0, 1);
    // Idle; en raised at slot 5 must wait for slot 0
    for (int s = 0; s <= 4; s++) add(0, s, 1, 1, 0, 0, 2'b00, 0, 0);
    for (int s = 5; s <= 15; s++) add(1, s, 1, 1, 0, 0, 2'b00, 0, 0);
    // Frame 3: counter jumps 6 -> 9
    add(1, 0, 1, 1, 1, 1, 2'b11, 1, 0);
    add(1, 1, 0, 1, 1, 1, 2'b10, 0, 0);
    add(1, 2, 0, 1, 1, 1, 2'b11, 0, 0);
    for (int s = 3; s <= 6; s++) add(1, s, 0, 1, 1, 1, 2'b00, 0, 0);
    e_serr = 1'b1;
    add(1, 9, 1, 1, 1, 0, 2'b00, 0, 0);
    for (int s = 10; s <= 15; s++) add(1, s, 1, 1, 0, 0, 2'b00, 0, 0);
    // Frame 4: clean restart
    add(1, 0, 1, 1, 1, 1, 2'b11, 1, 0);
    add(1, 1, 0, 1, 1, 1, 2'b10, 0, 0);
    add(1, 2, 0, 1, 1, 1, 2'b11, 0, 0);
    for (int s = 3; s <= 7; s++) add(1, s, 0, 1, 1, 1, 2'b00, 0, 0);
    run_table();

    // Asynchronous reset mid-frame at slot 8
    counter_sig = 4'd8; data_in = 1'b0;
    #2;
    reset_sig = 1'b0;
    #1;
    check("async reset outputs", bundle(), 7'd0);
    check("async reset ready", {6'd0, data_ready}, 7'd0);
    @(posedge clk_sig); #1;
    check("held reset outputs", bundle(), 7'd0);
    reset_sig = 1'b1;

    e_und = 1'b0; e_serr = 1'b0;
    for (int s = 9; s <= 15; s++) add(1, s, 1, 1, 0, 0, 2'b00, 0, 0);
    add(1, 0, 1, 1, 1, 1, 2'b11, 1, 0);
    add(1, 1, 1, 1, 1, 1, 2'b01, 0, 0);
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
